// File: rtl/muxkey_table.sv
// muxkey_table: small fully associative key -> data table with a
// valid/ready lookup channel and a one-deep registered result stage.
//
// Each entry holds a valid bit, a key and a data word. A lookup accepted on a
// clock edge is compared against the table contents as they were before that
// edge. The lowest matching valid index wins. A miss returns either
// default_out, sampled at acceptance, or zero, depending on HAS_DEFAULT.
//
// Optional feature: define MUXKEY_TABLE_MULTIHIT_EN to add the out_multihit
// output. It flags that two or more valid entries matched the looked-up key.
// Without the macro the port and its detection logic are absent.

module muxkey_table #(
    parameter int unsigned  NR_KEY      = 32'd4,
    parameter int unsigned  KEY_LEN     = 32'd2,
    parameter int unsigned  DATA_LEN    = 32'd8,
    parameter bit           HAS_DEFAULT = 1'b1,
    localparam int unsigned IDX_W       = (NR_KEY > 32'd1) ? $clog2(NR_KEY) : 32'd1
) (
    input  logic                clk,
    input  logic                rst,

    // table maintenance
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                clr,
    input  logic [DATA_LEN-1:0] default_out,

    // lookup request channel
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_LEN-1:0]  in_key,

    // lookup result channel
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic                out_hit,
`ifdef MUXKEY_TABLE_MULTIHIT_EN
    output logic                out_multihit,
`endif
    output logic [IDX_W-1:0]    out_idx
);

    // ------------------------------------------------------------------
    // Table storage. Keys and data carry no reset; only the valid bits
    // decide whether an entry participates in a lookup.
    // ------------------------------------------------------------------
    logic [NR_KEY-1:0]   entry_valid_r;
    logic [KEY_LEN-1:0]  entry_key_r  [NR_KEY];
    logic [DATA_LEN-1:0] entry_data_r [NR_KEY];

    // write decode
    logic                wr_in_range_s;
    logic [NR_KEY-1:0]   wr_sel_s;

    // lookup datapath
    logic                accept_s;
    logic [NR_KEY-1:0]   match_s;
    logic                hit_s;
    logic [IDX_W-1:0]    hit_idx_s;
    logic [DATA_LEN-1:0] hit_data_s;
    logic [DATA_LEN-1:0] miss_data_s;
    logic [DATA_LEN-1:0] result_data_s;

    // result register
    logic                out_valid_r;
    logic                out_hit_r;
    logic [IDX_W-1:0]    out_idx_r;
    logic [DATA_LEN-1:0] out_data_r;

`ifdef MUXKEY_TABLE_MULTIHIT_EN
    logic                multihit_s;
    logic                out_multihit_r;
`endif

    // ------------------------------------------------------------------
    // Handshake. The result stage is one deep: a new request can enter
    // when the stage is empty or is being drained in the same cycle.
    // ------------------------------------------------------------------
    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Decode the write strobe into a per-entry select, dropping out-of-range indices.
    always_comb begin
        wr_in_range_s = (32'(wr_idx) < NR_KEY);
        wr_sel_s      = '0;
        for (int i = 0; i < int'(NR_KEY); i++) begin
            if (wr_en && wr_in_range_s && (wr_idx == IDX_W'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // Load key and data of the addressed entry; reset blocks the write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NR_KEY); i++) begin
            if (!rst && wr_sel_s[i]) begin
                entry_key_r[i]  <= wr_key;
                entry_data_r[i] <= wr_data;
            end else begin
                entry_key_r[i]  <= entry_key_r[i];
                entry_data_r[i] <= entry_data_r[i];
            end
        end
    end

    // Valid bits: reset and clr invalidate, and a same-cycle write wins over clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_valid_r <= '0;
        end else begin
            for (int i = 0; i < int'(NR_KEY); i++) begin
                if (wr_sel_s[i]) begin
                    entry_valid_r[i] <= 1'b1;
                end else if (clr) begin
                    entry_valid_r[i] <= 1'b0;
                end else begin
                    entry_valid_r[i] <= entry_valid_r[i];
                end
            end
        end
    end

    // Compare the request key against every valid entry using registered table state.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < int'(NR_KEY); i++) begin
            if (entry_valid_r[i] && (entry_key_r[i] == in_key)) begin
                match_s[i] = 1'b1;
            end else begin
                match_s[i] = 1'b0;
            end
        end
    end

    // Priority select: walk upwards and keep the first (lowest) matching index.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = '0;
        hit_data_s = '0;
        for (int i = 0; i < int'(NR_KEY); i++) begin
            if (match_s[i] && !hit_s) begin
                hit_s      = 1'b1;
                hit_idx_s  = IDX_W'(i);
                hit_data_s = entry_data_r[i];
            end else begin
                hit_s      = hit_s;
                hit_idx_s  = hit_idx_s;
                hit_data_s = hit_data_s;
            end
        end
    end

    // Choose the miss value and the final data word for the result register.
    always_comb begin
        if (HAS_DEFAULT) begin
            miss_data_s = default_out;
        end else begin
            miss_data_s = '0;
        end
        if (hit_s) begin
            result_data_s = hit_data_s;
        end else begin
            result_data_s = miss_data_s;
        end
    end

    // Result stage: load on acceptance, drain on out_ready, otherwise hold untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_hit_r   <= 1'b0;
            out_idx_r   <= '0;
            out_data_r  <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_hit_r   <= hit_s;
            out_idx_r   <= hit_idx_s;
            out_data_r  <= result_data_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_hit_r   <= out_hit_r;
            out_idx_r   <= out_idx_r;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_hit_r   <= out_hit_r;
            out_idx_r   <= out_idx_r;
            out_data_r  <= out_data_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_hit   = out_hit_r;
    assign out_idx   = out_idx_r;
    assign out_data  = out_data_r;

`ifdef MUXKEY_TABLE_MULTIHIT_EN
    // Flag two or more matches: any match above the first match found.
    always_comb begin
        multihit_s = 1'b0;
        for (int i = 0; i < int'(NR_KEY); i++) begin
            if (match_s[i] && (IDX_W'(i) != hit_idx_s)) begin
                multihit_s = 1'b1;
            end else begin
                multihit_s = multihit_s;
            end
        end
    end

    // Register the multi-match flag alongside the rest of the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_multihit_r <= 1'b0;
        end else if (accept_s) begin
            out_multihit_r <= multihit_s;
        end else begin
            out_multihit_r <= out_multihit_r;
        end
    end

    assign out_multihit = out_multihit_r;
`endif

endmodule

// File: tb/tb_muxkey_table.sv
// Self-checking bench for muxkey_table (NR_KEY=4, KEY_LEN=2, DATA_LEN=8).
// The main instance uses HAS_DEFAULT=1. A second instance with HAS_DEFAULT=0
// shares all inputs and is used to check the zero-on-miss variant.
// The reference model keeps the table as plain arrays and evaluates each
// accepted lookup before applying that cycle's writes.

module tb_muxkey_table;

    localparam int NK = 4;
    localparam int KL = 2;
    localparam int DL = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst, wr_en, clr, in_valid, out_ready;
    logic [IW-1:0] wr_idx;
    logic [KL-1:0] wr_key, in_key;
    logic [DL-1:0] wr_data, default_out;

    logic          in_ready, out_valid, out_hit;
    logic [DL-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          in_ready0, out_valid0, out_hit0;
    logic [DL-1:0] out_data0;
    logic [IW-1:0] out_idx0;
`ifdef MUXKEY_TABLE_MULTIHIT_EN
    logic          out_multihit, out_multihit0;
`endif

    muxkey_table #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(1'b1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .clr(clr), .default_out(default_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_hit(out_hit),
`ifdef MUXKEY_TABLE_MULTIHIT_EN
        .out_multihit(out_multihit),
`endif
        .out_idx(out_idx)
    );

    muxkey_table #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .clr(clr), .default_out(default_out),
        .in_valid(in_valid), .in_ready(in_ready0), .in_key(in_key),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_hit(out_hit0),
`ifdef MUXKEY_TABLE_MULTIHIT_EN
        .out_multihit(out_multihit0),
`endif
        .out_idx(out_idx0)
    );

    always #5 clk = ~clk;

    // reference model
    bit            m_valid [NK];
    logic [KL-1:0] m_key   [NK];
    logic [DL-1:0] m_data  [NK];
    bit            e_valid, e_hit, e_multi;
    logic [IW-1:0] e_idx;
    logic [DL-1:0] e_data, e_data0;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic set_idle();
        rst = 1'b0; wr_en = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        wr_idx = 2'd0; wr_key = 2'd0; wr_data = 8'h00; in_key = 2'd0;
    endtask

    // Advance one clock, updating the model with the inputs currently driven.
    task automatic step();
        bit            acc;
        int            first;
        int            cnt;
        logic [DL-1:0] dflt;
        acc   = in_valid && (!e_valid || out_ready);
        first = -1;
        cnt   = 0;
        dflt  = default_out;
        for (int i = 0; i < NK; i++) begin
            if (m_valid[i] && (m_key[i] === in_key)) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NK; i++) m_valid[i] = 1'b0;
            e_valid = 1'b0; e_hit = 1'b0; e_idx = 2'd0;
            e_data = 8'h00; e_data0 = 8'h00; e_multi = 1'b0;
        end else begin
            if (acc) begin
                e_valid = 1'b1;
                e_hit   = (first >= 0);
                e_idx   = (first >= 0) ? IW'(first) : 2'd0;
                e_data  = (first >= 0) ? m_data[first] : dflt;
                e_data0 = (first >= 0) ? m_data[first] : 8'h00;
                e_multi = (cnt >= 2);
            end else if (out_ready) begin
                e_valid = 1'b0;
            end
            if (clr) begin
                for (int i = 0; i < NK; i++) m_valid[i] = 1'b0;
            end
            if (wr_en && (int'(wr_idx) < NK)) begin
                m_valid[wr_idx] = 1'b1;
                m_key[wr_idx]   = wr_key;
                m_data[wr_idx]  = wr_data;
            end
        end
        #1;
    endtask

    task automatic do_write(input logic [IW-1:0] idx, input logic [KL-1:0] k, input logic [DL-1:0] d);
        wr_en = 1'b1; wr_idx = idx; wr_key = k; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        default_out = 8'h00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_hit !== 1'b0 || out_idx !== 2'd0 || out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b h=%b i=%0d d=%h, want all zero", out_valid, out_hit, out_idx, out_data);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_hit();
        do_write(2'd0, 2'b01, 8'hA1);
        do_write(2'd2, 2'b11, 8'hC3);
        in_valid = 1'b1; in_key = 2'b11;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_hit !== 1'b1 || out_idx !== 2'd2 || out_data !== 8'hC3) begin
            tests_failed++;
            $display("FAIL hit_lookup: got v=%b h=%b i=%0d d=%h, want v=1 h=1 i=2 d=c3", out_valid, out_hit, out_idx, out_data);
        end
        tests_run++;
        if (out_data0 !== 8'hC3 || out_hit0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL hit_lookup_nodefault: got h=%b d=%h, want h=1 d=c3", out_hit0, out_data0);
        end
        step();
    endtask

    task automatic test_miss();
        default_out = 8'h5A;
        in_valid = 1'b1; in_key = 2'b10;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_hit !== 1'b0 || out_idx !== 2'd0 || out_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL miss_default: got v=%b h=%b i=%0d d=%h, want v=1 h=0 i=0 d=5a", out_valid, out_hit, out_idx, out_data);
        end
        tests_run++;
        if (out_hit0 !== 1'b0 || out_data0 !== 8'h00) begin
            tests_failed++;
            $display("FAIL miss_zero: got h=%b d=%h, want h=0 d=00", out_hit0, out_data0);
        end
        step();
    endtask

    task automatic test_multihit();
        do_clear();
        do_write(2'd1, 2'b01, 8'hB1);
        do_write(2'd3, 2'b01, 8'hD3);
        in_valid = 1'b1; in_key = 2'b01;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_hit !== 1'b1 || out_idx !== 2'd1 || out_data !== 8'hB1) begin
            tests_failed++;
            $display("FAIL multihit_lowest: got h=%b i=%0d d=%h, want h=1 i=1 d=b1", out_hit, out_idx, out_data);
        end
`ifdef MUXKEY_TABLE_MULTIHIT_EN
        tests_run++;
        if (out_multihit !== 1'b1) begin
            tests_failed++;
            $display("FAIL multihit_flag: got %b, want 1", out_multihit);
        end
`endif
        step();
    endtask

    task automatic test_backpressure();
        do_clear();
        do_write(2'd2, 2'b11, 8'hC3);
        in_valid = 1'b1; in_key = 2'b11; out_ready = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            wr_en = 1'b1; wr_idx = 2'd2; wr_key = 2'b11; wr_data = 8'hFF;
            step();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_hit !== 1'b1 || out_idx !== 2'd2 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: got v=%b d=%h h=%b i=%0d rdy=%b, want v=1 d=c3 h=1 i=2 rdy=0",
                         c, out_valid, out_data, out_hit, out_idx, in_ready);
            end
        end
        wr_en = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_hit !== 1'b1 || out_idx !== 2'd2 || out_data !== 8'hFF) begin
            tests_failed++;
            $display("FAIL after_release: got v=%b h=%b i=%0d d=%h, want v=1 h=1 i=2 d=ff", out_valid, out_hit, out_idx, out_data);
        end
        step();
    endtask

    task automatic test_same_cycle();
        do_clear();
        default_out = 8'h5A;
        wr_en = 1'b1; wr_idx = 2'd0; wr_key = 2'b01; wr_data = 8'h11;
        in_valid = 1'b1; in_key = 2'b01;
        step();
        wr_en = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_hit !== 1'b0 || out_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL same_cycle_miss: got v=%b h=%b d=%h, want v=1 h=0 d=5a", out_valid, out_hit, out_data);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_hit !== 1'b1 || out_idx !== 2'd0 || out_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL next_lookup_hit: got v=%b h=%b i=%0d d=%h, want v=1 h=1 i=0 d=11", out_valid, out_hit, out_idx, out_data);
        end
        step();
    endtask

    task automatic test_reset_pending();
        do_write(2'd1, 2'b10, 8'h77);
        in_valid = 1'b1; in_key = 2'b10; out_ready = 1'b0;
        step();
        rst = 1'b1; wr_en = 1'b1; wr_idx = 2'd3; wr_key = 2'b10; wr_data = 8'h99;
        step();
        rst = 1'b0; wr_en = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_hit !== 1'b0 || out_idx !== 2'd0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_drop: got v=%b h=%b i=%0d d=%h rdy=%b, want zeros rdy=1",
                     out_valid, out_hit, out_idx, out_data, in_ready);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_key = 2'b10;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_hit !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_table_miss: got v=%b h=%b, want v=1 h=0", out_valid, out_hit);
        end
        step();
    endtask

    task automatic test_random();
        set_idle();
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 59) == 0);
            clr         = ($urandom_range(0, 19) == 0);
            wr_en       = ($urandom_range(0, 2) == 0);
            wr_idx      = IW'($urandom_range(0, 3));
            wr_key      = KL'($urandom_range(0, 3));
            wr_data     = DL'($urandom);
            default_out = DL'($urandom);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_key      = KL'($urandom_range(0, 3));
            out_ready   = ($urandom_range(0, 3) != 0);
            step();
            tests_run++;
            if (out_valid !== e_valid || in_ready !== (!e_valid || out_ready)) begin
                tests_failed++;
                $display("FAIL rand_handshake[%0d]: got v=%b rdy=%b, want v=%b rdy=%b",
                         n, out_valid, in_ready, e_valid, (!e_valid || out_ready));
            end
            if (e_valid) begin
                tests_run++;
                if (out_hit !== e_hit || out_idx !== e_idx || out_data !== e_data || out_data0 !== e_data0) begin
                    tests_failed++;
                    $display("FAIL rand_result[%0d]: got h=%b i=%0d d=%h d0=%h, want h=%b i=%0d d=%h d0=%h",
                             n, out_hit, out_idx, out_data, out_data0, e_hit, e_idx, e_data, e_data0);
                end
`ifdef MUXKEY_TABLE_MULTIHIT_EN
                tests_run++;
                if (out_multihit !== e_multi) begin
                    tests_failed++;
                    $display("FAIL rand_multihit[%0d]: got %b, want %b", n, out_multihit, e_multi);
                end
`endif
            end
        end
        set_idle();
        step();
    endtask

    initial begin
        set_idle();
        default_out = 8'h00;
        @(negedge clk);
        test_reset();
        test_hit();
        test_miss();
        test_multihit();
        test_backpressure();
        test_same_cycle();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muxkey_table.md
MUXKEY_TABLE -- requirements
Module: muxkey_table

Interface
REQ-001 SHALL have parameter NR_KEY, default 4, number of table entries (>=1).
REQ-002 SHALL have parameter KEY_LEN, default 2, key width in bits.
REQ-003 SHALL have parameter DATA_LEN, default 8, data width in bits.
REQ-004 SHALL have parameter HAS_DEFAULT, default 1: 1 = miss returns default_out, 0 = miss returns zero.
REQ-005 SHALL derive localparam IDX_W = max(1, clog2(NR_KEY)).
REQ-006 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  table write strobe.
REQ-009 SHALL have port wr_idx  input  IDX_W  entry index to write.
REQ-010 SHALL have port wr_key  input  KEY_LEN  key to store.
REQ-011 SHALL have port wr_data  input  DATA_LEN  data to store.
REQ-012 SHALL have port clr  input  1  invalidate all entries.
REQ-013 SHALL have port default_out  input  DATA_LEN  miss value when HAS_DEFAULT=1.
REQ-014 SHALL have ports in_valid input 1, in_ready output 1, in_key input KEY_LEN: lookup request channel.
REQ-015 SHALL have ports out_valid output 1, out_ready input 1, out_data output DATA_LEN, out_hit output 1, out_idx output IDX_W: result channel.

Function
REQ-016 SHALL hold per entry: valid bit, KEY_LEN key, DATA_LEN data.
REQ-017 SHALL, on edge with wr_en=1 and wr_idx<NR_KEY, load key/data into entry wr_idx and set its valid bit; wr_idx>=NR_KEY SHALL be ignored.
REQ-018 SHALL, on edge with clr=1, clear every valid bit; with clr and wr_en in the same cycle, the written entry SHALL end valid and all others invalid.
REQ-019 SHALL drive in_ready = !out_valid || out_ready (combinational); request accepted on edge where in_valid && in_ready.
REQ-020 SHALL compare an accepted in_key against table contents as of before that edge; a same-cycle write or clr is not visible to that lookup.
REQ-021 SHALL select, on multiple valid matches, the lowest matching index.
REQ-022 SHALL register the result: out_valid=1 on the cycle after acceptance, latency 1, throughput 1 lookup/cycle when out_ready=1.
REQ-023 SHALL on hit set out_hit=1, out_idx=matching index, out_data=entry data.
REQ-024 SHALL on miss set out_hit=0, out_idx=0, out_data=default_out sampled at acceptance (HAS_DEFAULT=1) or 0 (HAS_DEFAULT=0).
REQ-025 SHALL hold out_data/out_hit/out_idx stable while out_valid=1 and out_ready=0; table writes SHALL NOT alter a held result.
REQ-026 SHALL clear out_valid on edge with out_valid && out_ready && !(in_valid && in_ready).

Reset
REQ-027 SHALL, on edge with rst=1, clear all entry valid bits and set out_valid=0, out_hit=0, out_idx=0, out_data=0; stored keys/data need not reset.
REQ-028 SHALL give rst priority over wr_en, clr and lookup acceptance; a result pending at reset SHALL be dropped.
REQ-029 SHALL drive in_ready=1 in the cycle after reset.

Configuration
REQ-030 SHALL, with macro MUXKEY_TABLE_MULTIHIT_EN defined, add port out_multihit output 1, registered with the result, =1 when two or more valid entries matched, reset 0.
REQ-031 SHALL, without MUXKEY_TABLE_MULTIHIT_EN, omit out_multihit and its compare-count logic; all other behaviour unchanged.

Verification (NR_KEY=4, KEY_LEN=2, DATA_LEN=8, HAS_DEFAULT=1)
REQ-032 SHALL cover: write {0:01->0xA1, 2:11->0xC3}, lookup 11 -> next cycle out_valid=1, out_hit=1, out_idx=2, out_data=0xC3.
REQ-033 SHALL cover: lookup 10 with default_out=0x5A -> out_hit=0, out_idx=0, out_data=0x5A; with HAS_DEFAULT=0 -> out_data=0x00.
REQ-034 SHALL cover: entries 1 and 3 both key 01, lookup 01 -> out_idx=1; out_multihit=1 when macro defined.
REQ-035 SHALL cover: out_ready=0 for 3 cycles with result 0xC3 pending while wr_en rewrites entry 2 to 0xFF -> out_data stays 0xC3, in_ready=0; after out_ready=1 a new lookup 11 returns 0xFF.
REQ-036 SHALL cover: wr_en idx0 key 01->0x11 with lookup 01 same cycle on empty table -> miss; next lookup 01 -> hit 0x11.
REQ-037 SHALL cover: rst=1 while out_valid=1 -> next cycle out_valid=0, all outputs 0, lookup of any previously written key misses.
